// File: rtl/hacd_pkg.sv
// hacd_pkg: shared HAWK AXI read-channel packet types and read-arbiter definitions.
package hacd_pkg;

   localparam int HAWK_RD_ARB_TIMEOUT = 4096;

   typedef struct packed {
      logic [63:0] addr;
      logic [7:0]  arlen;
      logic        arvalid;
      logic        rready;
   } axi_rd_reqpkt_t;

   typedef struct packed {
      logic arready;
   } axi_rd_rdypkt_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
   } axi_rd_resppkt_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ADDR  = 2'd1,
      ARB_DATA  = 2'd2,
      ARB_ERROR = 2'd3
   } hawk_rd_arb_state_t;

endpackage

// File: rtl/hawk_rr_arbiter.sv
// hawk_rr_arbiter: combinational round-robin pick, searching upward from last_i+1.
module hawk_rr_arbiter #(
   parameter  int N  = 3,
   localparam int IW = N > 1 ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic [IW-1:0] k;

   // Walk from farthest to nearest so the closest requester after last_i wins.
   always_comb begin
      idx_o = '0;
      k     = '0;
      for (int i = N; i >= 1; i--) begin
         k = IW'((int'(last_i) + i) % N);
         if (req_i[k]) idx_o = k;
      end
      gnt_o = |req_i ? N'(1) << idx_o : '0;
   end

endmodule

// File: rtl/hawk_axi_rd_arb.sv
// hawk_axi_rd_arb: round-robin owner of the single HAWK AXI read port; sequences AR,
// routes R beats to the owner until rlast, and latches a sticky error on timeout or length mismatch.
module hawk_axi_rd_arb
   import hacd_pkg::*;
#(
   parameter  int NUM_REQ     = 3,
   parameter  int TIMEOUT_CYC = HAWK_RD_ARB_TIMEOUT,
   localparam int IW          = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  axi_rd_reqpkt_t  req_reqpkt  [NUM_REQ],
   output axi_rd_rdypkt_t  req_rdypkt  [NUM_REQ],
   output axi_rd_resppkt_t req_resppkt [NUM_REQ],
   input  axi_rd_rdypkt_t  rd_rdypkt,
   output axi_rd_reqpkt_t  rd_reqpkt,
   input  axi_rd_resppkt_t rd_resppkt,
   output logic [IW-1:0]   grant_id,
   output logic            arb_busy,
   output logic            arb_err,
   output logic [1:0]      arb_state
);

   hawk_rd_arb_state_t state_q, state_d;
   logic [IW-1:0]      last_q, last_d, grant_q, grant_d, win;
   logic [63:0]        addr_q, addr_d;
   logic [7:0]         arlen_q, arlen_d, beat_q, beat_d;
   logic [15:0]        wd_q, wd_d;
   logic               err_q, err_d, hs;
   logic [NUM_REQ-1:0] arv, win_oh;

   hawk_rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i  (arv),
      .last_i (last_q),
      .gnt_o  (win_oh),
      .idx_o  (win)
   );

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign arv[g]                 = req_reqpkt[g].arvalid;
      assign req_rdypkt[g].arready  = (state_q == ARB_IDLE) && win_oh[g];
      assign req_resppkt[g]         = (state_q == ARB_DATA && grant_q == IW'(g)) ? rd_resppkt : '0;
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      arlen_d   = arlen_q;
      beat_d    = beat_q;
      wd_d      = '0;
      err_d     = err_q;
      hs        = 1'b0;
      rd_reqpkt = '{addr: addr_q, arlen: arlen_q, arvalid: 1'b0, rready: 1'b0};
      case (state_q)
         ARB_IDLE: if (|arv) begin
            addr_d  = req_reqpkt[win].addr;
            arlen_d = req_reqpkt[win].arlen;
            last_d  = win;
            grant_d = win;
            state_d = ARB_ADDR;
         end
         ARB_ADDR: begin
            rd_reqpkt.arvalid = 1'b1;
            hs                = rd_rdypkt.arready;
            beat_d            = hs ? 8'd0 : beat_q;
            state_d           = hs ? ARB_DATA : ARB_ADDR;
         end
         ARB_DATA: begin
            rd_reqpkt.rready = req_reqpkt[grant_q].rready;
            hs               = rd_resppkt.rvalid && rd_reqpkt.rready;
            beat_d           = hs ? beat_q + 8'd1 : beat_q;
            if (hs && rd_resppkt.rlast) begin
               err_d   = err_q | (beat_q != arlen_q);
               state_d = ARB_IDLE;
            end
         end
         default: wd_d = wd_q;
      endcase
      // Any stall cycle in ADDR/DATA advances the watchdog; a handshake clears it.
      if ((state_q == ARB_ADDR || state_q == ARB_DATA) && !hs) begin
         wd_d = wd_q + 16'd1;
         if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = ARB_ERROR;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         last_q  <= IW'(NUM_REQ - 1);
         grant_q <= '0;
         addr_q  <= '0;
         arlen_q <= '0;
         beat_q  <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         arlen_q <= arlen_d;
         beat_q  <= beat_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   assign grant_id  = grant_q;
   assign arb_busy  = state_q != ARB_IDLE;
   assign arb_err   = err_q;
   assign arb_state = state_q;

endmodule

// File: doc/hawk_axi_rd_arb.md
# hawk_axi_rd_arb

Round-robin arbiter and sequencer that shares the single HAWK AXI read master port among NUM_REQ read requesters (page-read manager, page-write manager, zero-space compacter). It grants one requester at a time, owns the AR handshake toward the AXI read FIFO, and routes R beats back to the owner until `rlast`. A watchdog flags hung transactions. It sits between the HAWK engines and the AXI read master FIFO.

## Interface
- NUM_REQ, 3: number of requesters; index 0 = pgrd_mngr.
- TIMEOUT_CYC, 4096: cycles without a handshake in ADDR or DATA before the block declares an error.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_reqpkt  in  hacd_pkg::axi_rd_reqpkt_t [NUM_REQ]  per-requester addr, arlen, arvalid, rready.
- req_rdypkt  out  hacd_pkg::axi_rd_rdypkt_t [NUM_REQ]  per-requester arready.
- req_resppkt  out  hacd_pkg::axi_rd_resppkt_t [NUM_REQ]  per-requester rvalid, rdata, rresp, rlast.
- rd_rdypkt  in  hacd_pkg::axi_rd_rdypkt_t  downstream arready.
- rd_reqpkt  out  hacd_pkg::axi_rd_reqpkt_t  downstream addr, arlen, arvalid, rready.
- rd_resppkt  in  hacd_pkg::axi_rd_resppkt_t  downstream R channel.
- grant_id  out  clog2(NUM_REQ)  current or last owner.
- arb_busy  out  1  state != ARB_IDLE.
- arb_err  out  1  sticky timeout or rlast-mismatch error.
- arb_state  out  2  debug state.

## Operation
- States: ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_ERROR.
- ARB_IDLE: if any req arvalid, pick a winner round-robin, starting the search at last_grant+1 mod NUM_REQ.
  - Same cycle: assert req_rdypkt[win].arready (combinational, one cycle).
  - Same cycle: capture addr and arlen into registers; load last_grant and grant_id.
  - Next state: ARB_ADDR.
- ARB_ADDR: drive rd_reqpkt.arvalid=1 with the captured addr/arlen, held stable until rd_rdypkt.arready. On the handshake: clear beat_cnt, go to ARB_DATA.
- ARB_DATA:
  - rd_reqpkt.rready = req_reqpkt[grant].rready.
  - req_resppkt[grant] = rd_resppkt; all other requesters see rvalid=0.
  - Each accepted beat (rvalid&&rready) increments 8-bit beat_cnt.
  - Accepted beat with rlast: if beat_cnt != arlen, set arb_err (transaction still completes); go to ARB_IDLE.
- Non-zero rresp is forwarded unmodified. It is not an arbiter error.
- Watchdog: a 16-bit counter increments each cycle in ARB_ADDR/ARB_DATA without a handshake and clears on any AR or R handshake. Reaching TIMEOUT_CYC sets arb_err and moves to ARB_ERROR.
- ARB_ERROR: terminal. All arready/arvalid/rready/rvalid outputs are 0. Only reset exits.
- Non-granted requesters always see arready=0 and rvalid=0. Their arvalid is ignored until they win.

## Timing
- Reset values:
  - state ARB_IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - grant_id 0; beat_cnt 0; watchdog 0; arb_err 0.
  - All packet outputs 0; downstream addr 0.
- AR latency: req arvalid in cycle T (IDLE) → req arready in T → downstream arvalid from T+1.
- Turnaround: last beat in cycle L → ARB_IDLE in L+1 (can grant in L+1) → next downstream arvalid in L+2.
- Simultaneous requests resolve by round-robin only; there is no fixed priority.
- A requester dropping arvalid after grant has no effect: the request was already captured.
- Reset mid-transaction abandons the burst immediately. The downstream FIFO is reset by the same rst_ni.
- arlen 255 produces 256 beats; the beat_cnt compare is 8-bit, with no wrap issue.

## Structure
- hacd_pkg gains the typedef hawk_rd_arb_state_t (2-bit enum) and the localparam HAWK_RD_ARB_TIMEOUT.
- Sub-module hawk_rr_arbiter: NUM_REQ request vector plus last_grant in; one-hot grant plus index out; purely combinational. It is reused later by the write-side arbiter.

## Test plan
- Single request: req1 addr 0x8000_1000, arlen 0 → arready1 in cycle T, downstream arvalid at T+1; one beat routed to req1 only; grant_id=1; back to IDLE.
- Simultaneous arvalid on all three after reset → grant order 0,1,2,0; each gets its own rdata (0xA0, 0xB1, 0xC2).
- Burst arlen 7 for req2 with rready toggled by req2 → exactly 8 beats forwarded; stalled beats held; arb_err stays 0.
- rlast on beat 3 of an arlen=7 burst → arb_err=1, state ARB_IDLE the next cycle, next request still served.
- Downstream arready held 0 for TIMEOUT_CYC cycles → arb_err=1, arb_state=ARB_ERROR, all handshake outputs 0; rst_ni low restores reset values.
- Reset asserted during ARB_DATA beat 2 → outputs at reset values asynchronously; first request after release goes to requester 0.
